// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction memory filler. On an accepted start it pops a
//   programmed number of instructions from the boot/program FIFO and writes
//   them to consecutive word addresses starting at byte address 0. The core
//   is held in reset (core_hold) for the whole load.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle load request, honoured only in IDLE
//   num_words    words to load, captured on an accepted start (clamped to capacity)
//   fifo_empty   FIFO has no data
//   fifo_data    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   FIFO pop strobe
//   mem_wr_addr  byte write address (bits [1:0] always 0)
//   mem_data_in  write data
//   mem_w_en     write enable
//   busy         load in progress (accepted start through the DONE cycle)
//   done         one-cycle completion pulse
//   core_hold    copy of busy, keeps the core in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] num_words,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_w_en,
  output logic                  busy,
  output logic                  done,
  output logic                  core_hold
);

  localparam int IDX_W = ADDR_WIDTH - 2;  // word index width
  localparam int CNT_W = ADDR_WIDTH - 1;  // count width, can hold the full capacity
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_DEPTH / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    w_en_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        idx_inc;

  // Clamp the requested length to the memory capacity so the index never wraps.
  always_comb begin
    count_next = num_words;
    if (num_words > MAX_WORDS) begin
      count_next = MAX_WORDS;
    end
  end

  // One bit wider than the index so a full-capacity load can reach count.
  assign idx_inc = {1'b0, idx_reg} + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      w_en_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      w_en_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            count_reg <= count_next;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            if (count_next == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // The pop itself is combinational; wait here as long as the FIFO is empty.
          if (!fifo_empty) begin
            state_reg <= S_CAPT;
          end
        end
        S_CAPT: begin
          // Address and data are loaded together so both only change entering WRITE.
          data_reg  <= fifo_data;
          addr_reg  <= {idx_reg, 2'b00};
          w_en_reg  <= 1'b1;
          state_reg <= S_WRITE;
        end
        S_WRITE: begin
          idx_reg <= idx_inc[IDX_W-1:0];
          if (idx_inc == count_reg) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_REQ;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en  = (state_reg == S_REQ) && !fifo_empty;
  assign mem_wr_addr = addr_reg;
  assign mem_data_in = data_reg;
  assign mem_w_en    = w_en_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign core_hold   = busy_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_words;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_data_in;
  logic        mem_w_en;
  logic        busy;
  logic        done;
  logic        core_hold;

  int errors = 0;
  int checks = 0;

  // FIFO model: written by the stimulus block, popped by the clocked process.
  logic [31:0] fifo_mem [0:2047];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        stall = 1'b0;

  // Observation log filled by the clocked process.
  logic [9:0]  log_addr [0:2047];
  logic [31:0] log_data [0:2047];
  int          wr_total = 0;
  int          pop_total = 0;
  int          done_total = 0;
  int          pop_while_empty = 0;

  assign fifo_empty = stall || (wr_ptr == rd_ptr);

  imem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .mem_wr_addr(mem_wr_addr), .mem_data_in(mem_data_in), .mem_w_en(mem_w_en),
    .busy(busy), .done(done), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pop_total <= pop_total + 1;
      if (fifo_empty) pop_while_empty <= pop_while_empty + 1;
    end
    if (mem_w_en) begin
      log_addr[wr_total] <= mem_wr_addr;
      log_data[wr_total] <= mem_data_in;
      wr_total <= wr_total + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic push(input logic [31:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic fifo_flush();
    wr_ptr = rd_ptr;
  endtask

  // Pulses start for one edge; returns #1 into cycle 1.
  task automatic start_load(input int n);
    @(negedge clk);
    num_words = 9'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called while in cycle cur; returns the cycle done was seen, or -1.
  task automatic wait_done(input int cur, input int budget, output int cyc);
    cyc = -1;
    for (int c = cur; c <= budget; c++) begin
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_words = '0;
    #12;
    checks++;
    if ({fifo_rd_en, mem_w_en, busy, done, core_hold} !== 5'b0 || mem_wr_addr !== 10'h0 || mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b we=%b busy=%b done=%b hold=%b addr=%h data=%h required all 0",
               fifo_rd_en, mem_w_en, busy, done, core_hold, mem_wr_addr, mem_data_in);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    logic [31:0] w [4];
    int w0, p0, cyc;
    w[0] = 32'h00000013; w[1] = 32'h00100093; w[2] = 32'h00200113; w[3] = 32'h002081B3;
    for (int i = 0; i < 4; i++) push(w[i]);
    w0 = wr_total; p0 = pop_total;
    start_load(4);
    checks++;
    if (busy !== 1'b1 || core_hold !== 1'b1) begin
      errors++; $display("FAIL basic_busy_c1: busy=%b hold=%b required 1/1", busy, core_hold);
    end
    wait_done(1, 100, cyc);
    checks++;
    if (cyc !== 13) begin errors++; $display("FAIL basic_done_cycle: got %0d required 13", cyc); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: busy=%b done=%b required 0/0", busy, done);
    end
    checks++;
    if (wr_total - w0 !== 4 || pop_total - p0 !== 4) begin
      errors++; $display("FAIL basic_counts: writes=%0d pops=%0d required 4/4", wr_total - w0, pop_total - p0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[w0+i] !== 10'(i*4) || log_data[w0+i] !== w[i]) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h data=%h required addr=%h data=%h",
                 i, log_addr[w0+i], log_data[w0+i], 10'(i*4), w[i]);
      end
    end
    $display("test_basic_load done: done_cycle=%0d", cyc);
  endtask

  task automatic test_zero_count();
    int w0, p0, cyc;
    push(32'hDEADBEEF);
    w0 = wr_total; p0 = pop_total;
    start_load(0);
    wait_done(1, 20, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d required 1", cyc); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_total != w0 || pop_total != p0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_activity: writes=%0d pops=%0d busy=%b required 0/0/0",
                         wr_total - w0, pop_total - p0, busy);
    end
    fifo_flush();
    $display("test_zero_count done: done_cycle=%0d", cyc);
  endtask

  task automatic test_clamp();
    int w0, cyc;
    for (int i = 0; i < 300; i++) push(32'hA000_0000 + 32'(i));
    w0 = wr_total;
    start_load(300);
    wait_done(1, 2000, cyc);
    checks++;
    if (cyc !== 769) begin errors++; $display("FAIL clamp_done_cycle: got %0d required 769", cyc); end
    @(posedge clk); #1;
    checks++;
    if (wr_total - w0 !== 256) begin errors++; $display("FAIL clamp_writes: got %0d required 256", wr_total - w0); end
    checks++;
    if (log_addr[w0+255] !== 10'h3FC || log_data[w0+255] !== 32'hA000_00FF) begin
      errors++; $display("FAIL clamp_last: addr=%h data=%h required 3fc/a00000ff", log_addr[w0+255], log_data[w0+255]);
    end
    checks++;
    if (wr_ptr - rd_ptr !== 44) begin errors++; $display("FAIL clamp_remaining: got %0d required 44", wr_ptr - rd_ptr); end
    fifo_flush();
    $display("test_clamp done: done_cycle=%0d", cyc);
  endtask

  task automatic test_stall();
    int w0, cyc, c;
    push(32'h11111111); push(32'h22222222);
    w0 = wr_total;
    start_load(2);
    cyc = -1;
    c = 1;
    while (c <= 40) begin
      if (c >= 4 && c <= 8) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en_c%0d: got %b required 0", c, fifo_rd_en); end
      end
      if (c == 3) stall = 1'b1;
      if (c == 9) stall = 1'b0;
      if (done === 1'b1) begin cyc = c; break; end
      @(posedge clk); #1;
      c++;
    end
    stall = 1'b0;
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL stall_done_cycle: got %0d required 12", cyc); end
    @(posedge clk); #1;
    checks++;
    if (wr_total - w0 !== 2 || log_addr[w0+1] !== 10'h004 || log_data[w0+1] !== 32'h22222222 || log_data[w0] !== 32'h11111111) begin
      errors++; $display("FAIL stall_writes: n=%0d addr1=%h data0=%h data1=%h required 2/004/11111111/22222222",
                         wr_total - w0, log_addr[w0+1], log_data[w0], log_data[w0+1]);
    end
    checks++;
    if (pop_while_empty !== 0) begin errors++; $display("FAIL pop_while_empty: got %0d required 0", pop_while_empty); end
    $display("test_stall done: done_cycle=%0d", cyc);
  endtask

  task automatic test_reset_mid_load();
    int w0;
    for (int i = 0; i < 8; i++) push(32'hB000_0000 + 32'(i));
    w0 = wr_total;
    start_load(8);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (mem_w_en !== 1'b1 || mem_wr_addr !== 10'h008) begin
      errors++; $display("FAIL midrst_write2: we=%b addr=%h required 1/008", mem_w_en, mem_wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, mem_w_en, busy, done, core_hold} !== 5'b0 || mem_wr_addr !== 10'h0 || mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs: rd=%b we=%b busy=%b done=%b hold=%b addr=%h data=%h required all 0",
               fifo_rd_en, mem_w_en, busy, done, core_hold, mem_wr_addr, mem_data_in);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // FIFO still holds data, so any pop or busy here means the FSM left IDLE.
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: busy=%b rd=%b required 0/0", busy, fifo_rd_en);
    end
    checks++;
    if (wr_total - w0 !== 2 || log_data[w0] !== 32'hB000_0000 || log_data[w0+1] !== 32'hB000_0001 || log_addr[w0+1] !== 10'h004) begin
      errors++; $display("FAIL midrst_mem: n=%0d d0=%h d1=%h a1=%h required 2/b0000000/b0000001/004",
                         wr_total - w0, log_data[w0], log_data[w0+1], log_addr[w0+1]);
    end
    fifo_flush();
    $display("test_reset_mid_load done");
  endtask

  task automatic test_start_while_busy();
    int w0, d0, cyc;
    for (int i = 0; i < 6; i++) push(32'hC000_0000 + 32'(i));
    w0 = wr_total; d0 = done_total;
    start_load(3);
    cyc = -1;
    for (int c = 1; c <= 16; c++) begin
      if (done === 1'b1 && cyc < 0) cyc = c;
      if (c == 4) begin start = 1'b1; num_words = 9'd7; end
      else if (c == 10) start = 1'b1;
      else start = 1'b0;
      if (c == 12 || c == 16) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_c%0d: busy=%b required 0", c, busy); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL busy_start_done_cycle: got %0d required 10", cyc); end
    checks++;
    if (wr_total - w0 !== 3 || done_total - d0 !== 1) begin
      errors++; $display("FAIL busy_start_counts: writes=%0d dones=%0d required 3/1", wr_total - w0, done_total - d0);
    end
    fifo_flush();
    $display("test_start_while_busy done: done_cycle=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_count();
    test_clamp();
    test_stall();
    test_reset_mid_load();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
